vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed-mode pixel iterator.
- Generates VGA horizontal/vertical timing for any mode from per-region parameters, with programmable sync polarity and a pixel-clock enable.
- Produces registered, glitch-free sync, active-area flags, 0-based active coordinates and single-cycle event strobes.
- Sits between the system clock and the pixel/framebuffer fetch logic.

---
 rtl/vga_timing_gen.sv | 204 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with parameterised regions and sync polarity.
// Latency: 1 clk from a pix_en edge to the new position on every registered output.
// Backpressure: pix_en=0 freezes the position and level outputs; strobes drop to 0.
//
// Ports:
//   clk, rst (async, active-low)  : clock and reset
//   pix_en                        : advance one pixel on this clk edge
//   h_sync, v_sync                : sync pulses at H_POL / V_POL asserted level
//   draw_active, pix_x, pix_y     : visible-area flag and 0-based active coordinates
//   line_start, frame_start,
//   draw_end, screen_end          : single-cycle position strobes
//   frame_cnt                     : 16-bit frame counter, only when FRAME_CNT_EN is defined
//
// Optional feature macro: FRAME_CNT_EN
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          draw_active,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          draw_end,
    output logic          screen_end
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject modes that cannot be represented or have empty regions.
    if (H_TOTAL > (1 << CW)) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_chk_h_regions
        $error("vga_timing_gen: every horizontal region must be at least 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_v_regions
        $error("vga_timing_gen: every vertical region must be at least 1");
    end

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ON       = 1'(H_POL != 0);
    localparam logic          V_ON       = 1'(V_POL != 0);

    // Position counters
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    // Registered outputs
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          draw_active_q, draw_active_d;
    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          draw_end_q, draw_end_d;
    logic          screen_end_q, screen_end_d;

    // Next position
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CW'(1);
                end
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    // Outputs are decoded from the next position only when the position moves.
    // Holding the registered values otherwise keeps the forced reset values
    // intact until the first advance, rather than decoding the parked
    // (H_TOTAL-1, V_TOTAL-1) reset position.
    always_comb begin
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        draw_active_d = draw_active_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        draw_end_d    = 1'b0;
        screen_end_d  = 1'b0;
        if (pix_en) begin
            h_sync_d      = (h_d >= HS_START && h_d < HS_END) ? H_ON : ~H_ON;
            v_sync_d      = (v_d >= VS_START && v_d < VS_END) ? V_ON : ~V_ON;
            draw_active_d = (h_d < H_ACT) && (v_d < V_ACT);
            pix_x_d       = (h_d < H_ACT) ? h_d : '0;
            pix_y_d       = (v_d < V_ACT) ? v_d : V_ACT_LAST;
            line_start_d  = (h_d == '0);
            frame_start_d = (h_d == '0) && (v_d == '0);
            draw_end_d    = (h_d == H_LAST) && (v_d == V_ACT_LAST);
            screen_end_d  = (h_d == H_LAST) && (v_d == V_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            h_sync_q      <= ~H_ON;
            v_sync_q      <= ~V_ON;
            draw_active_q <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            draw_end_q    <= 1'b0;
            screen_end_q  <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            draw_active_q <= draw_active_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            draw_end_q    <= draw_end_d;
            screen_end_q  <= screen_end_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign draw_active = draw_active_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign draw_end    = draw_end_q;
    assign screen_end  = screen_end_q;

`ifdef FRAME_CNT_EN
    // The frame entered straight out of reset is frame 0, so the first
    // frame_start after reset only arms the counter.
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        fs_seen_q, fs_seen_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        fs_seen_d   = fs_seen_q;
        if (frame_start_d) begin
            if (fs_seen_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                fs_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            fs_seen_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            fs_seen_q   <= fs_seen_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Instance A: small mode 8x6, positive sync.
    localparam int A_HA = 4, A_HFP = 1, A_HS = 2, A_HB = 1;
    localparam int A_VA = 3, A_VFP = 1, A_VS = 1, A_VB = 1;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HB;
    localparam int A_TOT = A_HT * (A_VA + A_VFP + A_VS + A_VB);
    // Instance B: default 800-wide horizontal timing, negative sync,
    // shortened vertical so that whole frames fit the cycle budget.
    localparam int B_HA = 800, B_HFP = 56, B_HS = 120, B_HB = 64;
    localparam int B_VA = 5, B_VFP = 2, B_VS = 3, B_VB = 2;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HB;
    localparam int B_TOT = B_HT * (B_VA + B_VFP + B_VS + B_VB);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en_a = 1'b0;
    logic pix_en_b = 1'b0;

    logic a_h_sync, a_v_sync, a_draw_active, a_line_start, a_frame_start, a_draw_end, a_screen_end;
    logic [10:0] a_pix_x, a_pix_y;
    logic b_h_sync, b_v_sync, b_draw_active, b_line_start, b_frame_start, b_draw_end, b_screen_end;
    logic [10:0] b_pix_x, b_pix_y;
`ifdef FRAME_CNT_EN
    logic [15:0] a_frame_cnt, b_frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(11), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VB), .H_POL(1), .V_POL(1)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(pix_en_a),
        .h_sync(a_h_sync), .v_sync(a_v_sync), .draw_active(a_draw_active),
        .pix_x(a_pix_x), .pix_y(a_pix_y), .line_start(a_line_start),
        .frame_start(a_frame_start), .draw_end(a_draw_end), .screen_end(a_screen_end)
`ifdef FRAME_CNT_EN
        , .frame_cnt(a_frame_cnt)
`endif
    );

    vga_timing_gen #(
        .CW(11), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VB), .H_POL(0), .V_POL(0)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_en_b),
        .h_sync(b_h_sync), .v_sync(b_v_sync), .draw_active(b_draw_active),
        .pix_x(b_pix_x), .pix_y(b_pix_y), .line_start(b_line_start),
        .frame_start(b_frame_start), .draw_end(b_draw_end), .screen_end(b_screen_end)
`ifdef FRAME_CNT_EN
        , .frame_cnt(b_frame_cnt)
`endif
    );

    logic [28:0] obs_a, obs_b;
    assign obs_a = {a_h_sync, a_v_sync, a_draw_active, a_pix_x, a_pix_y,
                    a_line_start, a_frame_start, a_draw_end, a_screen_end};
    assign obs_b = {b_h_sync, b_v_sync, b_draw_active, b_pix_x, b_pix_y,
                    b_line_start, b_frame_start, b_draw_end, b_screen_end};

    // Reference model: raster position as a single linear pixel index within
    // the frame; 'moved' = advanced on the last edge, 'fresh' = no advance
    // since reset (outputs still at their forced reset values).
    int pos_a = A_TOT - 1;
    int pos_b = B_TOT - 1;
    bit mv_a = 1'b0, mv_b = 1'b0;
    bit fr_a = 1'b1, fr_b = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_a <= A_TOT - 1; mv_a <= 1'b0; fr_a <= 1'b1;
            pos_b <= B_TOT - 1; mv_b <= 1'b0; fr_b <= 1'b1;
        end else begin
            if (pix_en_a) begin
                pos_a <= (pos_a + 1) % A_TOT; mv_a <= 1'b1; fr_a <= 1'b0;
            end else begin
                mv_a <= 1'b0;
            end
            if (pix_en_b) begin
                pos_b <= (pos_b + 1) % B_TOT; mv_b <= 1'b1; fr_b <= 1'b0;
            end else begin
                mv_b <= 1'b0;
            end
        end
    end

    function automatic logic [28:0] exp_out(int pos, bit moved, bit fresh,
                                            int ha, int hfp, int hs, int hb,
                                            int va, int vfp, int vs, int vb,
                                            bit hpol, bit vpol);
        int ht, vt, h, v;
        logic hsy, vsy, da, ls, fs, de, se;
        logic [10:0] px, py;
        ht = ha + hfp + hs + hb;
        vt = va + vfp + vs + vb;
        if (fresh) return {~hpol, ~vpol, 1'b0, 11'd0, 11'd0, 4'b0000};
        h   = pos % ht;
        v   = pos / ht;
        hsy = (h >= ha + hfp && h < ha + hfp + hs) ? hpol : ~hpol;
        vsy = (v >= va + vfp && v < va + vfp + vs) ? vpol : ~vpol;
        da  = (h < ha) && (v < va);
        px  = (h < ha) ? 11'(h) : 11'd0;
        py  = (v < va) ? 11'(v) : 11'(va - 1);
        ls  = moved && (h == 0);
        fs  = moved && (pos == 0);
        de  = moved && (h == ht - 1) && (v == va - 1);
        se  = moved && (pos == ht * vt - 1);
        return {hsy, vsy, da, px, py, ls, fs, de, se};
    endfunction

    function automatic logic [28:0] exp_a();
        return exp_out(pos_a, mv_a, fr_a, A_HA, A_HFP, A_HS, A_HB, A_VA, A_VFP, A_VS, A_VB, 1'b1, 1'b1);
    endfunction

    function automatic logic [28:0] exp_b();
        return exp_out(pos_b, mv_b, fr_b, B_HA, B_HFP, B_HS, B_HB, B_VA, B_VFP, B_VS, B_VB, 1'b0, 1'b0);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        pix_en_a = 1'b1;
        pix_en_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_a !== {2'b00, 1'b0, 11'd0, 11'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, {2'b00, 1'b0, 11'd0, 11'd0, 4'b0000});
        end
        n_checks++;
        if (obs_b !== {2'b11, 1'b0, 11'd0, 11'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, {2'b11, 1'b0, 11'd0, 11'd0, 4'b0000});
        end
        pix_en_a = 1'b0;
        pix_en_b = 1'b0;
    endtask

    task automatic test_first_frame();
        int se_edge;
        se_edge = -1;
        @(negedge clk);
        rst = 1'b1;
        pix_en_a = 1'b1;
        for (int e = 1; e <= A_TOT + 2; e++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL first_frame edge=%0d got=%h exp=%h", e, obs_a, exp_a());
            end
            if (e == 1) begin
                n_checks++;
                if ({a_frame_start, a_line_start, a_draw_active, a_pix_x, a_pix_y} !== {3'b111, 22'd0}) begin
                    n_fail++;
                    $display("FAIL first_edge_origin got=%b_%b_%b x=%0d y=%0d exp=1_1_1 x=0 y=0",
                             a_frame_start, a_line_start, a_draw_active, a_pix_x, a_pix_y);
                end
            end
            if (a_screen_end && se_edge < 0) se_edge = e;
            if (e == A_TOT + 1) begin
                n_checks++;
                if (a_frame_start !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_restart got=%b exp=1", a_frame_start);
                end
            end
        end
        n_checks++;
        if (se_edge != A_TOT) begin
            n_fail++;
            $display("FAIL screen_end_edge got=%0d exp=%0d", se_edge, A_TOT);
        end
    endtask

    task automatic test_pix_en_pattern();
        logic [3:0] pat;
        int ls_len;
        int ls_max;
        pat = 4'b1001;
        ls_len = 0;
        ls_max = 0;
        for (int i = 0; i < 64; i++) begin
            pix_en_a = pat[3 - (i % 4)];
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL pix_en_pattern i=%0d got=%h exp=%h", i, obs_a, exp_a());
            end
            ls_len = a_line_start ? ls_len + 1 : 0;
            if (ls_len > ls_max) ls_max = ls_len;
        end
        n_checks++;
        if (ls_max != 1) begin
            n_fail++;
            $display("FAIL line_start_width got=%0d exp=1", ls_max);
        end
    endtask

    task automatic test_pix_en_random();
        for (int i = 0; i < 300; i++) begin
            pix_en_a = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL pix_en_random i=%0d got=%h exp=%h", i, obs_a, exp_a());
            end
        end
        pix_en_a = 1'b0;
    endtask

    task automatic test_default_mode();
        int last_ls, last_fs, n_de;
        bit bad_lp, bad_fp;
        last_ls = -1; last_fs = -1; n_de = 0;
        bad_lp = 1'b0; bad_fp = 1'b0;
        pix_en_b = 1'b1;
        for (int c = 0; c < B_TOT + 600; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL default_mode c=%0d got=%h exp=%h", c, obs_b, exp_b());
            end
            if (b_line_start) begin
                if (last_ls >= 0 && c - last_ls != B_HT) bad_lp = 1'b1;
                last_ls = c;
            end
            if (b_frame_start) begin
                if (last_fs >= 0 && c - last_fs != B_TOT) bad_fp = 1'b1;
                last_fs = c;
            end
            if (b_draw_end) n_de++;
        end
        n_checks++;
        if (bad_lp || bad_fp) begin
            n_fail++;
            $display("FAIL periods line_bad=%0d frame_bad=%0d exp line=%0d frame=%0d", bad_lp, bad_fp, B_HT, B_TOT);
        end
        n_checks++;
        if (n_de != 1) begin
            n_fail++;
            $display("FAIL draw_end_count got=%0d exp=1", n_de);
        end
    endtask

    task automatic test_reset_mid_frame();
        int target, n;
        target = 3 * B_HT + 300;
        n = 0;
        pix_en_b = 1'b1;
        while (pos_b != target && n < B_TOT + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (b_pix_x !== 11'd300 || b_pix_y !== 11'd3) begin
            n_fail++;
            $display("FAIL reach_300_3 got x=%0d y=%0d exp x=300 y=3", b_pix_x, b_pix_y);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs_b !== {2'b11, 1'b0, 11'd0, 11'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset_b got=%h exp=%h", obs_b, {2'b11, 1'b0, 11'd0, 11'd0, 4'b0000});
        end
        n_checks++;
        if (obs_a !== {2'b00, 1'b0, 11'd0, 11'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset_a got=%h exp=%h", obs_a, {2'b00, 1'b0, 11'd0, 11'd0, 4'b0000});
        end
        @(negedge clk);
        rst = 1'b1;
        pix_en_a = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_b !== exp_b() || b_frame_start !== 1'b1 || b_pix_x !== 11'd0 || b_pix_y !== 11'd0) begin
            n_fail++;
            $display("FAIL restart_origin got=%h exp=%h", obs_b, exp_b());
        end
    endtask

`ifdef FRAME_CNT_EN
    task automatic test_frame_cnt();
        int k;
        k = 0;
        // A restarted one edge ago with frame_start; counter must be 0.
        n_checks++;
        if (a_frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_first got=%0d exp=0", a_frame_cnt);
        end
        for (int c = 0; c < 3 * A_TOT; c++) begin
            @(posedge clk);
            #1;
            if (a_frame_start) begin
                k++;
                n_checks++;
                if (a_frame_cnt !== 16'(k)) begin
                    n_fail++;
                    $display("FAIL frame_cnt_seq got=%0d exp=%0d", a_frame_cnt, k);
                end
            end
        end
        n_checks++;
        if (b_frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_b got=%0d exp=0", b_frame_cnt);
        end
        pix_en_a = 1'b0;
        force u_a.frame_cnt_q = 16'hFFFF;
        #1;
        release u_a.frame_cnt_q;
        @(negedge clk);
        pix_en_a = 1'b1;
        for (int c = 0; c < A_TOT + 2 && !a_frame_start; c++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (a_frame_start !== 1'b1 || a_frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL frame_cnt_wrap fs=%b got=%h exp=0000", a_frame_start, a_frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_pix_en_pattern();
        test_pix_en_random();
        test_default_mode();
        test_reset_mid_frame();
`ifdef FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
